core_seq: RTL and testbench
===========================

# core_seq

Multi-cycle instruction sequencer for the xcore datapath. It replaces the free-running fetch/pc_reg pair with a state machine that talks to instruction and data memory over valid/ready handshakes. It holds the architectural PC and the instruction register, and gates every architectural write (GPR, CSR, PC) to exactly one cycle per retired instruction. Decode, ALU, regfile and CSR file stay combinational/unchanged around it.

## Interface
Clocking: one clock; reset is asynchronous and active-low. Ports `clk`, `rst_n`.
- ADDR_W, 32, instruction/data address width
- RESET_PC, 32'h8000_0000, PC value loaded at reset
- CNT_W, 64, width of the retired-instruction counter
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  fetch request accepted
- imem_addr  out  ADDR_W  fetch address (= pc)
- imem_rsp_valid  in  1  fetch response valid
- imem_rsp_data  in  32  fetched instruction
- imem_rsp_err  in  1  fetch bus error
- dmem_req_valid  out  1  data request valid
- dmem_req_ready  in  1  data request accepted
- dmem_we  out  1  data request is a store
- dmem_rsp_valid  in  1  data response valid
- dmem_rsp_data  in  32  load data
- dnpc  in  ADDR_W  next PC from ex
- dec_reg_wen, dec_dmem_req, dec_dmem_wen, dec_csr_wen1, dec_csr_wen2  in  1 each  raw decode controls
- pc  out  ADDR_W  architectural PC
- inst  out  32  instruction register
- mem_rdata  out  32  registered load data to wb
- reg_wen, csr_wen1, csr_wen2  out  1 each  gated write enables
- retire  out  1  one-cycle pulse per retired instruction
- instret  out  CNT_W  retired-instruction count
- fault  out  1  sticky fault flag

## Operation
- States: BOOT, F_REQ, F_WAIT, EXEC, M_REQ, M_WAIT, WB, FAULT.
- BOOT: entered on reset; -> F_REQ unconditionally.
- F_REQ: imem_req_valid=1, imem_addr=pc; on imem_req_ready -> F_WAIT.
- F_WAIT: on imem_rsp_valid: if imem_rsp_err -> FAULT; else inst <= imem_rsp_data, -> EXEC.
- EXEC: decode settles on stable inst; dec_dmem_req=1 -> M_REQ, else -> WB.
- M_REQ: dmem_req_valid=1, dmem_we=dec_dmem_wen; on dmem_req_ready -> M_WAIT.
- M_WAIT: on dmem_rsp_valid: mem_rdata <= dmem_rsp_data (stores too; value unused), -> WB.
- WB: reg_wen=dec_reg_wen, csr_wen1=dec_csr_wen1, csr_wen2=dec_csr_wen2, retire=1, instret+1 (wraps modulo 2^CNT_W). If dnpc[1:0]!=0 -> FAULT with pc unchanged and no writes/retire; else pc <= dnpc, -> F_REQ.
- FAULT: sticky; no requests, all write enables 0, fault=1; exit only via reset.
- reg_wen/csr_wen*/retire are 0 in every state except WB.
- imem/dmem responses arriving outside their WAIT state are ignored.

## Timing
- Reset values: state=BOOT, pc=RESET_PC, inst=32'h0000_0013, mem_rdata=0, instret=0, fault=0; all valid/enable/retire outputs 0 (Moore-decoded from state).
- Reset mid-transaction: state returns to BOOT immediately; outstanding responses after reset are ignored until F_WAIT.
- Handshake: request valid held high, address/we stable, until ready; response earliest cycle after acceptance.
- Min CPI with zero-wait memory: 4 cycles non-memory (F_REQ, F_WAIT, EXEC, WB), 6 cycles load/store.
- pc, instret update on clock edge ending WB; new imem_addr visible in following F_REQ.

## Structure
- core_seq_pkg: state enum, NOP constant 32'h0000_0013, default RESET_PC.
- No sub-module; instret counter inline. xcore instantiates core_seq in place of fetch/pc_reg and routes gated enables to regfile/csr_regs/mem.

## Test plan
- Reset release, ready/rsp always 1, addi stream -> first imem_addr=8000_0000 at cycle 2, retire every 4 cycles, pc +4 each, instret=3 after 3 instrs.
- Load with dmem_req_ready low 3 cycles, rsp 2 cycles later -> dmem_req_valid held 4 cycles, mem_rdata=rsp data, one reg_wen pulse in WB, CPI=11.
- imem_rsp_err=1 on second fetch -> FAULT, fault=1, pc=8000_0004, no further imem_req_valid for 50 cycles.
- jalr to dnpc=8000_0102 -> FAULT, no reg_wen, retire=0, instret unchanged.
- rst_n asserted during M_WAIT, then released -> pc=8000_0000, instret=0, stale dmem_rsp_valid ignored.
- CNT_W=4, retire 17 instructions -> instret wraps to 1.

Source files
------------

// File: rtl/core_seq_pkg.sv
// Shared constants for the xcore instruction sequencer: state encodings,
// the reset instruction and the default boot address.
package core_seq_pkg;

   typedef logic [2:0] seq_state_t;

   localparam seq_state_t ST_BOOT   = 3'd0;
   localparam seq_state_t ST_F_REQ  = 3'd1;
   localparam seq_state_t ST_F_WAIT = 3'd2;
   localparam seq_state_t ST_EXEC   = 3'd3;
   localparam seq_state_t ST_M_REQ  = 3'd4;
   localparam seq_state_t ST_M_WAIT = 3'd5;
   localparam seq_state_t ST_WB     = 3'd6;
   localparam seq_state_t ST_FAULT  = 3'd7;

   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

   // A next-PC is only legal when it is word aligned.
   function automatic logic pc_aligned(input logic [1:0] low_bits);
      return (low_bits == 2'b00);
   endfunction

endpackage

// File: rtl/core_seq.sv
// Multi-cycle sequencer: fetches over imem, optionally accesses dmem, and
// commits PC/GPR/CSR writes in a single WB cycle per retired instruction.
module core_seq
   import core_seq_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
   parameter int                CNT_W    = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rsp_valid,
   input  logic [31:0]       imem_rsp_data,
   input  logic              imem_rsp_err,
   output logic              dmem_req_valid,
   input  logic              dmem_req_ready,
   output logic              dmem_we,
   input  logic              dmem_rsp_valid,
   input  logic [31:0]       dmem_rsp_data,
   input  logic [ADDR_W-1:0] dnpc,
   input  logic              dec_reg_wen,
   input  logic              dec_dmem_req,
   input  logic              dec_dmem_wen,
   input  logic              dec_csr_wen1,
   input  logic              dec_csr_wen2,
   output logic [ADDR_W-1:0] pc,
   output logic [31:0]       inst,
   output logic [31:0]       mem_rdata,
   output logic              reg_wen,
   output logic              csr_wen1,
   output logic              csr_wen2,
   output logic              retire,
   output logic [CNT_W-1:0]  instret,
   output logic              fault
);

   seq_state_t        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       inst_q, inst_d;
   logic [31:0]       mdata_q, mdata_d;
   logic [CNT_W-1:0]  instret_q, instret_d;
   logic              npc_ok_s;
   logic              commit_s;

   assign npc_ok_s = pc_aligned(dnpc[1:0]);
   // A misaligned dnpc turns WB into a fault with nothing committed.
   assign commit_s = (state_q == ST_WB) && npc_ok_s;

   // Next-state and architectural register update logic.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      mdata_d   = mdata_q;
      instret_d = instret_q;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_F_REQ;
         end
         ST_F_REQ: begin
            if (imem_req_ready) begin
               state_d = ST_F_WAIT;
            end else begin
               state_d = ST_F_REQ;
            end
         end
         ST_F_WAIT: begin
            if (imem_rsp_valid) begin
               if (imem_rsp_err) begin
                  state_d = ST_FAULT;
               end else begin
                  inst_d  = imem_rsp_data;
                  state_d = ST_EXEC;
               end
            end else begin
               state_d = ST_F_WAIT;
            end
         end
         ST_EXEC: begin
            if (dec_dmem_req) begin
               state_d = ST_M_REQ;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_M_REQ: begin
            if (dmem_req_ready) begin
               state_d = ST_M_WAIT;
            end else begin
               state_d = ST_M_REQ;
            end
         end
         ST_M_WAIT: begin
            if (dmem_rsp_valid) begin
               mdata_d = dmem_rsp_data;
               state_d = ST_WB;
            end else begin
               state_d = ST_M_WAIT;
            end
         end
         ST_WB: begin
            if (npc_ok_s) begin
               pc_d      = dnpc;
               instret_d = instret_q + CNT_W'(1);
               state_d   = ST_F_REQ;
            end else begin
               state_d = ST_FAULT;
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_FAULT;
         end
      endcase
   end

   // Sequencer state and architectural registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_BOOT;
         pc_q      <= RESET_PC;
         inst_q    <= NOP_INST;
         mdata_q   <= 32'h0000_0000;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         mdata_q   <= mdata_d;
         instret_q <= instret_d;
      end
   end

   assign imem_req_valid = (state_q == ST_F_REQ);
   assign imem_addr      = pc_q;
   assign dmem_req_valid = (state_q == ST_M_REQ);
   assign dmem_we        = (state_q == ST_M_REQ) && dec_dmem_wen;
   assign reg_wen        = commit_s && dec_reg_wen;
   assign csr_wen1       = commit_s && dec_csr_wen1;
   assign csr_wen2       = commit_s && dec_csr_wen2;
   assign retire         = commit_s;
   assign fault          = (state_q == ST_FAULT);
   assign pc             = pc_q;
   assign inst           = inst_q;
   assign mem_rdata      = mdata_q;
   assign instret        = instret_q;

endmodule

// File: tb/tb_core_seq.sv
// Directed + randomized bench for core_seq; a second instance with a 4-bit
// retire counter shares the stimulus to exercise counter wrap.
module tb_core_seq;
   import core_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_ready, imem_rsp_valid, imem_rsp_err;
   logic        dmem_req_ready, dmem_rsp_valid;
   logic [31:0] imem_rsp_data, dmem_rsp_data, dnpc;
   logic        dec_reg_wen, dec_dmem_req, dec_dmem_wen, dec_csr_wen1, dec_csr_wen2;

   logic        imem_req_valid, dmem_req_valid, dmem_we;
   logic [31:0] imem_addr, pc, inst, mem_rdata;
   logic        reg_wen, csr_wen1, csr_wen2, retire, fault;
   logic [63:0] instret;

   logic        imem_req_valid_b, dmem_req_valid_b, dmem_we_b;
   logic [31:0] imem_addr_b, pc_b, inst_b, mem_rdata_b;
   logic        reg_wen_b, csr_wen1_b, csr_wen2_b, retire_b, fault_b;
   logic [3:0]  instret_b;

   core_seq dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
      .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_data(dmem_rsp_data), .dnpc(dnpc),
      .dec_reg_wen(dec_reg_wen), .dec_dmem_req(dec_dmem_req), .dec_dmem_wen(dec_dmem_wen),
      .dec_csr_wen1(dec_csr_wen1), .dec_csr_wen2(dec_csr_wen2),
      .pc(pc), .inst(inst), .mem_rdata(mem_rdata), .reg_wen(reg_wen),
      .csr_wen1(csr_wen1), .csr_wen2(csr_wen2), .retire(retire), .instret(instret), .fault(fault)
   );

   core_seq #(.CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid_b), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr_b),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
      .dmem_req_valid(dmem_req_valid_b), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we_b),
      .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_data(dmem_rsp_data), .dnpc(dnpc),
      .dec_reg_wen(dec_reg_wen), .dec_dmem_req(dec_dmem_req), .dec_dmem_wen(dec_dmem_wen),
      .dec_csr_wen1(dec_csr_wen1), .dec_csr_wen2(dec_csr_wen2),
      .pc(pc_b), .inst(inst_b), .mem_rdata(mem_rdata_b), .reg_wen(reg_wen_b),
      .csr_wen1(csr_wen1_b), .csr_wen2(csr_wen2_b), .retire(retire_b), .instret(instret_b), .fault(fault_b)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          n_ret = 0, n_rw = 0, n_c1 = 0, n_c2 = 0, n_ireq = 0, n_dreq = 0;
   int          last_wb = -1;
   logic [31:0] m_pc;
   logic [63:0] m_ret;
   logic [31:0] m_mdata;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and tally pulses from both instances.
   task automatic tick();
      @(negedge clk);
      cyc++;
      n_ret  += int'(retire) + int'(retire_b);
      n_rw   += int'(reg_wen) + int'(reg_wen_b);
      n_c1   += int'(csr_wen1) + int'(csr_wen1_b);
      n_c2   += int'(csr_wen2) + int'(csr_wen2_b);
      n_ireq += int'(imem_req_valid) + int'(imem_req_valid_b);
      n_dreq += int'(dmem_req_valid) + int'(dmem_req_valid_b) + int'(dmem_we) + int'(dmem_we_b);
   endtask

   task automatic model_reset();
      m_pc    = 32'h8000_0000;
      m_ret   = 64'd0;
      m_mdata = 32'h0000_0000;
      last_wb = -1;
   endtask

   task automatic apply_reset(input bit check_vals);
      rst_n = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
      tick(); tick();
      model_reset();
      if (check_vals) begin
         chk("rst_pc", {pc, pc_b}, {m_pc, m_pc});
         chk("rst_inst", inst, 32'h0000_0013);
         chk("rst_mem_rdata", mem_rdata, 32'h0000_0000);
         chk("rst_instret", {instret, 4'(instret_b)}, 68'd0);
         chk("rst_outputs", {imem_req_valid, dmem_req_valid, dmem_we, reg_wen, csr_wen1,
                             csr_wen2, retire, fault, fault_b}, 9'd0);
      end
      rst_n = 1'b1;
   endtask

   // One instruction from fetch to commit (or fault), with chosen stall counts.
   task automatic run_instr(input bit mem, input bit we, input bit rw, input bit c1, input bit c2,
                            input logic [31:0] npc, input int fs, input int fd, input int ds,
                            input int dd, input bit ferr, input bit rst_mid);
      logic [31:0] idata, ddata;
      int n, exp_cpi, r0, w0, a0, b0, q0;
      idata = $urandom; ddata = $urandom;
      dec_reg_wen = rw; dec_dmem_req = mem; dec_dmem_wen = we;
      dec_csr_wen1 = c1; dec_csr_wen2 = c2; dnpc = npc;
      r0 = n_ret; w0 = n_rw; a0 = n_c1; b0 = n_c2; q0 = n_dreq;
      n = 0;
      while (imem_req_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("imem_req_valid", imem_req_valid, 1);
      chk("imem_addr", {imem_addr, imem_addr_b}, {m_pc, m_pc});
      for (int k = 0; k < fs; k++) begin
         imem_req_ready = 1'b0;
         tick();
         chk("imem_hold", {imem_req_valid, imem_addr}, {1'b1, m_pc});
      end
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      for (int k = 0; k < fd; k++) tick();
      imem_rsp_valid = 1'b1; imem_rsp_data = idata; imem_rsp_err = ferr;
      tick();
      imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
      if (ferr) begin
         chk("fault_on_err", {fault, fault_b}, 2'b11);
         chk("pc_after_err", pc, m_pc);
         chk("no_retire_err", n_ret - r0, 0);
         return;
      end
      chk("inst", {inst, inst_b}, {idata, idata});
      tick();
      if (mem) begin
         chk("dmem_req", {dmem_req_valid, dmem_we}, {1'b1, we});
         for (int k = 0; k < ds; k++) begin
            dmem_req_ready = 1'b0;
            tick();
            chk("dmem_hold", {dmem_req_valid, dmem_we}, {1'b1, we});
         end
         dmem_req_ready = 1'b1;
         tick();
         dmem_req_ready = 1'b0;
         if (rst_mid) begin
            tick();
            rst_n = 1'b0;
            #1;
            chk("midrst_pc", pc, 32'h8000_0000);
            chk("midrst_instret", instret, 64'd0);
            chk("midrst_idle", {dmem_req_valid, imem_req_valid, retire, fault}, 4'd0);
            tick(); tick();
            model_reset();
            rst_n = 1'b1;
            dmem_rsp_valid = 1'b1;
            dmem_rsp_data = 32'hDEAD_BEEF;
            return;
         end
         for (int k = 0; k < dd; k++) tick();
         dmem_rsp_valid = 1'b1; dmem_rsp_data = ddata;
         tick();
         dmem_rsp_valid = 1'b0;
         m_mdata = ddata;
         chk("mem_rdata", {mem_rdata, mem_rdata_b}, {ddata, ddata});
      end
      exp_cpi = 4 + fs + fd + (mem ? (2 + ds + dd) : 0);
      if (npc[1:0] == 2'b00) begin
         chk("retire", retire, 1);
         chk("wb_enables", {reg_wen, csr_wen1, csr_wen2}, {rw, c1, c2});
         if (last_wb >= 0) chk("cpi", cyc - last_wb, exp_cpi);
         last_wb = cyc;
         tick();
         m_pc = npc;
         m_ret = m_ret + 64'd1;
         chk("pc", {pc, pc_b}, {m_pc, m_pc});
         chk("next_imem_addr", imem_addr, m_pc);
         chk("instret", instret, m_ret);
         chk("instret_wrap", instret_b, m_ret[3:0]);
         chk("retire_pulses", n_ret - r0, 2);
         chk("reg_wen_pulses", n_rw - w0, 2 * int'(rw));
         chk("csr_pulses", {32'(n_c1 - a0), 32'(n_c2 - b0)}, {32'(2 * int'(c1)), 32'(2 * int'(c2))});
         chk("dmem_cycles", n_dreq - q0, mem ? 2 * (ds + 1) * (1 + int'(we)) : 0);
      end else begin
         chk("no_commit_misaligned", {retire, reg_wen, csr_wen1, csr_wen2}, 4'd0);
         tick();
         chk("fault_misaligned", {fault, fault_b}, 2'b11);
         chk("pc_held", pc, m_pc);
         chk("instret_held", instret, m_ret);
         chk("no_pulses_misaligned", {32'(n_ret - r0), 32'(n_rw - w0)}, 64'd0);
      end
   endtask

   task automatic fault_idle_check();
      int q, d;
      q = n_ireq; d = n_dreq;
      imem_req_ready = 1'b1; dmem_req_ready = 1'b1;
      imem_rsp_valid = 1'b1; dmem_rsp_valid = 1'b1;
      repeat (50) tick();
      imem_req_ready = 1'b0; dmem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0; dmem_rsp_valid = 1'b0;
      chk("fault_no_requests", {32'(n_ireq - q), 32'(n_dreq - d)}, 64'd0);
      chk("fault_sticky", {fault, fault_b}, 2'b11);
   endtask

   initial begin
      logic [31:0] npc;
      bit          mem_r;
      dec_reg_wen = 1'b0; dec_dmem_req = 1'b0; dec_dmem_wen = 1'b0;
      dec_csr_wen1 = 1'b0; dec_csr_wen2 = 1'b0; dnpc = 32'h0;
      imem_rsp_data = 32'h0; dmem_rsp_data = 32'h0;

      // Reset values and first fetch on the cycle after BOOT.
      apply_reset(1'b1);
      chk("boot_no_fetch", imem_req_valid, 0);
      tick();
      chk("first_fetch", {imem_req_valid, imem_addr}, {1'b1, 32'h8000_0000});

      // Three zero-wait addi instructions.
      for (int i = 0; i < 3; i++)
         run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, m_pc + 32'd4, 0, 0, 0, 0, 1'b0, 1'b0);
      chk("three_retired", instret, 64'd3);

      // Load with a 3-cycle ready stall and 2 idle response cycles.
      run_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, m_pc + 32'd4, 0, 0, 3, 2, 1'b0, 1'b0);

      // Random mix of loads, stores, CSR writes, branches and stalls.
      for (int i = 0; i < 20; i++) begin
         mem_r = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) npc = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
         else npc = m_pc + 32'd4;
         run_instr(mem_r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), npc,
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0);
         if (m_ret == 64'd17) chk("wrap_at_17", instret_b, 4'd1);
      end

      // Misaligned jalr target faults without committing.
      run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0102, 0, 0, 0, 0, 1'b0, 1'b0);
      fault_idle_check();

      // Fetch bus error on the second fetch.
      apply_reset(1'b0);
      run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, m_pc + 32'd4, 0, 0, 0, 0, 1'b0, 1'b0);
      run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, m_pc + 32'd4, 1, 1, 0, 0, 1'b1, 1'b0);
      chk("pc_at_fetch_fault", pc, 32'h8000_0004);
      fault_idle_check();

      // Reset asserted during M_WAIT; the stale load response is ignored.
      apply_reset(1'b0);
      run_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, m_pc + 32'd4, 0, 0, 0, 0, 1'b0, 1'b0);
      run_instr(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, m_pc + 32'd4, 0, 0, 0, 0, 1'b0, 1'b0);
      run_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, m_pc + 32'd4, 0, 0, 1, 0, 1'b0, 1'b1);
      run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, m_pc + 32'd4, 0, 0, 0, 0, 1'b0, 1'b0);
      chk("stale_rsp_ignored", {mem_rdata, mem_rdata_b}, 64'd0);
      chk("restart_instret", instret, 64'd1);
      dmem_rsp_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
